// File: rtl/reorder_bound_sequencer_pkg.sv
// Shared types and constants for the reorder bound sequencer and its bound register file.
package reorder_pkg;

  localparam int          NUM_SLOTS   = 8;
  localparam int          SLOT_W      = 3;
  localparam logic [15:0] EMPTY_X_MIN = 16'hFFFF;
  localparam logic [15:0] EMPTY_X_MAX = 16'h0000;

  typedef struct packed {
    logic [15:0] x_min;
    logic [15:0] x_max;
  } seg_entry_t;

  typedef enum logic [2:0] {
    COLLECT,
    PENDING,
    WR_Y,
    WR_XMIN,
    WR_XMAX,
    DONE
  } seq_state_t;

endpackage

// File: rtl/reorder_bound_sequencer_if.sv
// Segment-entry channel from the character segmentation stage into the sequencer.
interface reorder_bound_sequencer_if;
  logic        seg_valid;
  logic        seg_ready;
  logic [15:0] seg_x_min;
  logic [15:0] seg_x_max;
  logic        seg_last;
  logic [15:0] plate_y_min;
  logic [15:0] plate_y_max;

  modport master (
    output seg_valid, seg_x_min, seg_x_max, seg_last, plate_y_min, plate_y_max,
    input  seg_ready
  );

  modport slave (
    input  seg_valid, seg_x_min, seg_x_max, seg_last, plate_y_min, plate_y_max,
    output seg_ready
  );
endinterface

// File: rtl/reorder_bound_sequencer_frame_gap_monitor.sv
// Tracks whether a video frame is in flight by counting tlast beats after tuser.
module frame_gap_monitor #(
  parameter int NUMBER_OF_ROWS = 480
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic tvalid,
  input  logic tready,
  input  logic tuser,
  input  logic tlast,
  output logic in_frame
);
  localparam int ROW_W = $clog2(NUMBER_OF_ROWS);

  logic [ROW_W-1:0] row_count;
  logic             beat;

  assign beat = tvalid && tready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      in_frame  <= 1'b0;
      row_count <= '0;
    end else if (beat) begin
      if (tuser) begin
        // Start of frame wins over a coincident end of line.
        in_frame  <= 1'b1;
        row_count <= tlast ? ROW_W'(1) : '0;
      end else if (tlast) begin
        if (row_count == ROW_W'(NUMBER_OF_ROWS - 1)) begin
          in_frame  <= 1'b0;
          row_count <= '0;
        end else begin
          row_count <= row_count + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/reorder_bound_sequencer.sv
// Buffers one plate's character boxes and writes them into the reorder bound registers in the frame gap.
module reorder_bound_sequencer
  import reorder_pkg::*;
#(
  parameter int NUMBER_OF_ROWS = 480
) (
  input  logic              aclk,
  input  logic              aresetn,
  reorder_bound_sequencer_if.slave seg,
  input  logic              mon_tvalid,
  input  logic              mon_tready,
  input  logic              mon_tuser,
  input  logic              mon_tlast,
  output logic [SLOT_W-1:0] bound_x_min_addr,
  output logic [15:0]       bound_x_min,
  output logic              bound_x_min_we,
  output logic [SLOT_W-1:0] bound_x_max_addr,
  output logic [15:0]       bound_x_max,
  output logic              bound_x_max_we,
  output logic [15:0]       bound_y_min,
  output logic              bound_y_min_we,
  output logic [15:0]       bound_y_max,
  output logic              bound_y_max_we,
  output logic              busy,
  output logic              update_done,
  output logic              overflow
);
  seq_state_t        state, state_nxt;
  seg_entry_t        entries [NUM_SLOTS];
  logic [SLOT_W:0]   count;
  logic [SLOT_W-1:0] idx;
  logic [15:0]       y_min_q, y_max_q;
  logic              ovf_q;
  logic              run_q;
  logic              in_frame;
  logic              accept;
  logic              slot_used;

  frame_gap_monitor #(.NUMBER_OF_ROWS(NUMBER_OF_ROWS)) u_mon (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .tvalid   (mon_tvalid),
    .tready   (mon_tready),
    .tuser    (mon_tuser),
    .tlast    (mon_tlast),
    .in_frame (in_frame)
  );

  assign accept    = seg.seg_valid && seg.seg_ready;
  assign slot_used = {1'b0, idx} < count;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= COLLECT;
    else          state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt = state;
    unique case (state)
      COLLECT: if (accept && seg.seg_last) state_nxt = PENDING;
      PENDING: if (!in_frame)              state_nxt = WR_Y;
      WR_Y:                                state_nxt = WR_XMIN;
      WR_XMIN:                             state_nxt = WR_XMAX;
      WR_XMAX: state_nxt = (idx == SLOT_W'(NUM_SLOTS - 1)) ? DONE : WR_XMIN;
      DONE:                                state_nxt = COLLECT;
      default:                             state_nxt = COLLECT;
    endcase
  end

  // run_q keeps seg_ready low while reset is held and for the first cycle after release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count   <= '0;
      idx     <= '0;
      y_min_q <= '0;
      y_max_q <= '0;
      ovf_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      run_q <= 1'b1;
      unique case (state)
        COLLECT: if (accept) begin
          if (count < (SLOT_W+1)'(NUM_SLOTS)) count <= count + 1'b1;
          else                                ovf_q <= 1'b1;
          if (seg.seg_last) begin
            y_min_q <= seg.plate_y_min;
            y_max_q <= seg.plate_y_max;
          end
        end
        WR_Y:    idx <= '0;
        WR_XMAX: idx <= idx + 1'b1;
        DONE: begin
          count <= '0;
          ovf_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: entry storage has no reset; count alone decides which slots hold valid data.
  always_ff @(posedge aclk) begin
    if (state == COLLECT && accept && count < (SLOT_W+1)'(NUM_SLOTS))
      entries[count[SLOT_W-1:0]] <= '{x_min: seg.seg_x_min, x_max: seg.seg_x_max};
  end

  // Write ports decode straight from state, so asserting reset drops every enable at once.
  always_comb begin
    seg.seg_ready    = (state == COLLECT) && run_q;
    busy             = state inside {PENDING, WR_Y, WR_XMIN, WR_XMAX};
    update_done      = (state == DONE);
    overflow         = ovf_q;
    bound_x_min_addr = '0;
    bound_x_min      = '0;
    bound_x_min_we   = 1'b0;
    bound_x_max_addr = '0;
    bound_x_max      = '0;
    bound_x_max_we   = 1'b0;
    bound_y_min      = '0;
    bound_y_min_we   = 1'b0;
    bound_y_max      = '0;
    bound_y_max_we   = 1'b0;
    unique case (state)
      WR_Y: begin
        bound_y_min    = y_min_q;
        bound_y_min_we = 1'b1;
        bound_y_max    = y_max_q;
        bound_y_max_we = 1'b1;
      end
      WR_XMIN: begin
        bound_x_min_addr = idx;
        bound_x_min      = slot_used ? entries[idx].x_min : EMPTY_X_MIN;
        bound_x_min_we   = 1'b1;
      end
      WR_XMAX: begin
        bound_x_max_addr = idx;
        bound_x_max      = slot_used ? entries[idx].x_max : EMPTY_X_MAX;
        bound_x_max_we   = 1'b1;
      end
      default: ;
    endcase
  end
endmodule
